// File: rtl/gelato_bank_read_arbiter.sv
// Banked register-file access arbiter: writeback owns its bank, reads are granted
// round-robin per bank, and bank read data is routed back to the granted requester.
module gelato_bank_read_arbiter #(
  parameter int unsigned BANK_NUM = 4,
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned WARP_W   = 5,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned DATA_W   = 32,
  localparam int unsigned BANK_W  = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [REQ_NUM-1:0]           req_valid,
  input  logic [REQ_NUM*BANK_W-1:0]    req_bank,
  input  logic [REQ_NUM*WARP_W-1:0]    req_warp,
  input  logic [REQ_NUM*REG_W-1:0]     req_reg,
  input  logic [REQ_NUM*TAG_W-1:0]     req_tag,
  output logic [REQ_NUM-1:0]           req_ready,
  input  logic                         wb_valid,
  input  logic [BANK_W-1:0]            wb_bank,
  input  logic [WARP_W-1:0]            wb_warp,
  input  logic [REG_W-1:0]             wb_reg,
  input  logic [DATA_W-1:0]            wb_data,
  output logic                         wb_ready,
  output logic [BANK_NUM-1:0]          bank_rd_en,
  output logic [BANK_NUM*WARP_W-1:0]   bank_rd_warp,
  output logic [BANK_NUM*REG_W-1:0]    bank_rd_reg,
  input  logic [BANK_NUM*DATA_W-1:0]   bank_rd_data,
  output logic [BANK_NUM-1:0]          bank_wr_en,
  output logic [WARP_W-1:0]            bank_wr_warp,
  output logic [REG_W-1:0]             bank_wr_reg,
  output logic [DATA_W-1:0]            bank_wr_data,
  output logic [REQ_NUM-1:0]           resp_valid,
  output logic [REQ_NUM*DATA_W-1:0]    resp_data,
  output logic [REQ_NUM*TAG_W-1:0]     resp_tag
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [PTR_W-1:0]          r_rr_ptr [BANK_NUM];
  logic [REQ_NUM-1:0]        r_own_valid;
  logic [REQ_NUM*BANK_W-1:0] r_own_bank;
  logic [REQ_NUM*TAG_W-1:0]  r_own_tag;

  logic                        w_act;
  logic                        w_wr;
  logic [REQ_NUM-1:0]          w_req_ready;
  logic [BANK_NUM-1:0]         w_rd_en;
  logic [BANK_NUM-1:0]         w_wr_en;
  logic [BANK_NUM*WARP_W-1:0]  w_rd_warp;
  logic [BANK_NUM*REG_W-1:0]   w_rd_reg;
  logic [PTR_W-1:0]            w_win [BANK_NUM];
  logic [BANK_W-1:0]           w_gnt_bank [REQ_NUM];

  assign w_act = rdy & ~rst;
  assign w_wr  = w_act & wb_valid;

  // Per-bank cyclic search from the bank's pointer; a bank under writeback is skipped.
  always_comb begin : arb
    logic found;
    int   idx;
    w_req_ready = '0;
    w_rd_en     = '0;
    w_wr_en     = '0;
    w_rd_warp   = '0;
    w_rd_reg    = '0;
    found       = 1'b0;
    idx         = 0;
    for (int b = 0; b < BANK_NUM; b++) w_win[b] = '0;
    for (int r = 0; r < REQ_NUM; r++) w_gnt_bank[r] = '0;
    if (w_wr) w_wr_en[wb_bank] = 1'b1;
    for (int b = 0; b < BANK_NUM; b++) begin
      found = 1'b0;
      if (w_act && !w_wr_en[b]) begin
        for (int k = 0; k < REQ_NUM; k++) begin
          idx = (int'(r_rr_ptr[b]) + k) % int'(REQ_NUM);
          if (!found && req_valid[idx] && (req_bank[idx*BANK_W +: BANK_W] == BANK_W'(b))) begin
            found                         = 1'b1;
            w_req_ready[idx]              = 1'b1;
            w_rd_en[b]                    = 1'b1;
            w_win[b]                      = PTR_W'(idx);
            w_gnt_bank[idx]               = BANK_W'(b);
            w_rd_warp[b*WARP_W +: WARP_W] = req_warp[idx*WARP_W +: WARP_W];
            w_rd_reg[b*REG_W +: REG_W]    = req_reg[idx*REG_W +: REG_W];
          end
        end
      end
    end
  end

  assign req_ready    = w_req_ready;
  assign wb_ready     = w_act;
  assign bank_rd_en   = w_rd_en;
  assign bank_rd_warp = w_rd_warp;
  assign bank_rd_reg  = w_rd_reg;
  assign bank_wr_en   = w_wr_en;
  assign bank_wr_warp = w_wr ? wb_warp : '0;
  assign bank_wr_reg  = w_wr ? wb_reg  : '0;
  assign bank_wr_data = w_wr ? wb_data : '0;

  // Pointer advance and owner pipeline; owner valid clears itself so responses are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANK_NUM; b++) r_rr_ptr[b] <= '0;
      r_own_valid <= '0;
      r_own_bank  <= '0;
      r_own_tag   <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (w_rd_en[b]) begin
          r_rr_ptr[b] <= (w_win[b] == PTR_W'(REQ_NUM - 1)) ? '0 : PTR_W'(w_win[b] + PTR_W'(1));
        end
      end
      r_own_valid <= w_req_ready;
      for (int r = 0; r < REQ_NUM; r++) begin
        if (w_req_ready[r]) begin
          r_own_bank[r*BANK_W +: BANK_W] <= w_gnt_bank[r];
          r_own_tag[r*TAG_W +: TAG_W]    <= req_tag[r*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Bank data arrives the cycle after the strobe, so it is steered straight through.
  always_comb begin
    resp_valid = r_own_valid & {REQ_NUM{~rst}};
    resp_data  = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (resp_valid[r]) begin
        resp_data[r*DATA_W +: DATA_W] =
          bank_rd_data[int'(r_own_bank[r*BANK_W +: BANK_W])*DATA_W +: DATA_W];
      end
    end
  end

  assign resp_tag = r_own_tag;

endmodule

// File: tb/tb_gelato_bank_read_arbiter.sv
// Directed, table-driven bench for gelato_bank_read_arbiter with hand-computed expectations.
module tb_gelato_bank_read_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic [3:0]   req_valid;
  logic [7:0]   req_bank;
  logic [19:0]  req_warp;
  logic [19:0]  req_reg;
  logic [15:0]  req_tag;
  logic [3:0]   req_ready;
  logic         wb_valid;
  logic [1:0]   wb_bank;
  logic [4:0]   wb_warp;
  logic [4:0]   wb_reg;
  logic [31:0]  wb_data;
  logic         wb_ready;
  logic [3:0]   bank_rd_en;
  logic [19:0]  bank_rd_warp;
  logic [19:0]  bank_rd_reg;
  logic [127:0] bank_rd_data;
  logic [3:0]   bank_wr_en;
  logic [4:0]   bank_wr_warp;
  logic [4:0]   bank_wr_reg;
  logic [31:0]  bank_wr_data;
  logic [3:0]   resp_valid;
  logic [127:0] resp_data;
  logic [15:0]  resp_tag;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gelato_bank_read_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_bank(req_bank), .req_warp(req_warp),
    .req_reg(req_reg), .req_tag(req_tag), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_bank(wb_bank), .wb_warp(wb_warp), .wb_reg(wb_reg),
    .wb_data(wb_data), .wb_ready(wb_ready),
    .bank_rd_en(bank_rd_en), .bank_rd_warp(bank_rd_warp), .bank_rd_reg(bank_rd_reg),
    .bank_rd_data(bank_rd_data),
    .bank_wr_en(bank_wr_en), .bank_wr_warp(bank_wr_warp), .bank_wr_reg(bank_wr_reg),
    .bank_wr_data(bank_wr_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag)
  );

  typedef struct {
    logic       rdy;
    logic       wbv;
    logic [1:0] wbb;
    logic [3:0] rv;
    logic [7:0] rb;
    logic [3:0] e_ready;
    logic [3:0] e_rd;
    logic [3:0] e_wr;
    logic       e_wbr;
    logic [3:0] e_resp;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_idle();
    rdy = 1'b1; req_valid = '0; req_bank = '0; wb_valid = 1'b0; wb_bank = '0;
  endtask

  logic [19:0]  exp_warp, exp_reg;
  logic [127:0] exp_data;

  initial begin
    //            rdy  wbv wbb   rv       rb      ready    rd       wr      wbr   resp
    tbl[0]  = '{1'b1,1'b0,2'd0,4'b1111,8'hAA,4'b0001,4'b0100,4'b0000,1'b1,4'b0000};
    tbl[1]  = '{1'b1,1'b0,2'd0,4'b1111,8'hAA,4'b0010,4'b0100,4'b0000,1'b1,4'b0001};
    tbl[2]  = '{1'b1,1'b0,2'd0,4'b1111,8'hAA,4'b0100,4'b0100,4'b0000,1'b1,4'b0010};
    tbl[3]  = '{1'b1,1'b0,2'd0,4'b1111,8'hAA,4'b1000,4'b0100,4'b0000,1'b1,4'b0100};
    tbl[4]  = '{1'b1,1'b0,2'd0,4'b1111,8'hAA,4'b0001,4'b0100,4'b0000,1'b1,4'b1000};
    tbl[5]  = '{1'b1,1'b1,2'd1,4'b0011,8'h0D,4'b0010,4'b1000,4'b0010,1'b1,4'b0001};
    tbl[6]  = '{1'b1,1'b0,2'd0,4'b0001,8'h0D,4'b0001,4'b0010,4'b0000,1'b1,4'b0010};
    tbl[7]  = '{1'b0,1'b1,2'd2,4'b0011,8'h00,4'b0000,4'b0000,4'b0000,1'b0,4'b0001};
    tbl[8]  = '{1'b0,1'b0,2'd0,4'b0011,8'h00,4'b0000,4'b0000,4'b0000,1'b0,4'b0000};
    tbl[9]  = '{1'b0,1'b0,2'd0,4'b0011,8'h00,4'b0000,4'b0000,4'b0000,1'b0,4'b0000};
    tbl[10] = '{1'b1,1'b0,2'd0,4'b0011,8'h00,4'b0001,4'b0001,4'b0000,1'b1,4'b0000};
    tbl[11] = '{1'b1,1'b0,2'd0,4'b0010,8'h00,4'b0010,4'b0001,4'b0000,1'b1,4'b0001};
    tbl[12] = '{1'b1,1'b0,2'd0,4'b0000,8'h00,4'b0000,4'b0000,4'b0000,1'b1,4'b0010};

    for (int r = 0; r < 4; r++) begin
      req_warp[r*5 +: 5] = 5'(r + 3);
      req_reg[r*5 +: 5]  = 5'(2*r + 1);
      req_tag[r*4 +: 4]  = 4'(r + 8);
    end
    wb_warp = 5'd7; wb_reg = 5'd9; wb_data = 32'h1234_5678;
    bank_rd_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

    // Reset with random inputs
    rst = 1'b1;
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      rdy = 1'b1; req_valid = 4'($urandom); req_bank = 8'($urandom);
      wb_valid = 1'($urandom); wb_bank = 2'($urandom);
      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rd_en", bank_rd_en, 0);
      chk("rst_wr_en", bank_wr_en, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_tag", resp_tag, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();

    // Round-robin, writeback priority and freeze sequences
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      rdy = tbl[i].rdy; wb_valid = tbl[i].wbv; wb_bank = tbl[i].wbb;
      req_valid = tbl[i].rv; req_bank = tbl[i].rb;
      #3;
      chk($sformatf("v%0d_req_ready", i), req_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_rd_en", i), bank_rd_en, tbl[i].e_rd);
      chk($sformatf("v%0d_wr_en", i), bank_wr_en, tbl[i].e_wr);
      chk($sformatf("v%0d_wb_ready", i), wb_ready, tbl[i].e_wbr);
      chk($sformatf("v%0d_resp_valid", i), resp_valid, tbl[i].e_resp);
      if (tbl[i].e_wr != 0) begin
        chk($sformatf("v%0d_wr_data", i), bank_wr_data, 32'h1234_5678);
        chk($sformatf("v%0d_wr_warp", i), bank_wr_warp, 5'd7);
      end
    end

    // All four requesters to distinct banks
    @(posedge clk); #1;
    drive_idle();
    req_valid = 4'b1111; req_bank = 8'hE4;
    #3;
    for (int b = 0; b < 4; b++) begin
      exp_warp[b*5 +: 5] = 5'(b + 3);
      exp_reg[b*5 +: 5]  = 5'(2*b + 1);
    end
    chk("par_req_ready", req_ready, 4'b1111);
    chk("par_rd_en", bank_rd_en, 4'b1111);
    chk("par_rd_warp", bank_rd_warp, exp_warp);
    chk("par_rd_reg", bank_rd_reg, exp_reg);
    @(posedge clk); #1;
    req_valid = '0;
    bank_rd_data = {32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
    #3;
    for (int r = 0; r < 4; r++) exp_data[r*32 +: 32] = 32'hBEEF_0000 + 32'(r);
    chk("par_resp_valid", resp_valid, 4'b1111);
    chk("par_resp_data", resp_data, exp_data);
    chk("par_resp_tag", resp_tag, 16'hBA98);
    @(posedge clk); #1;
    #3;
    chk("par_resp_pulse", resp_valid, 4'b0000);

    // Reset one cycle after a grant drops the response and rewinds pointers
    @(posedge clk); #1;
    req_valid = 4'b0100; req_bank = 8'hAA;
    #3;
    chk("rm_req_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    #3;
    chk("rm_resp_t1", resp_valid, 4'b0000);
    chk("rm_ready_in_rst", req_ready, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("rm_resp_t2", resp_valid, 4'b0000);
    @(posedge clk); #1;
    req_valid = 4'b1111; req_bank = 8'h99;
    #3;
    chk("rm_ptr_ready", req_ready, 4'b0011);
    chk("rm_ptr_rd_en", bank_rd_en, 4'b0110);

    @(posedge clk); #1;
    drive_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
